alu_rs_multi: RTL and testbench

- Multi-entry successor to the single-slot ALU reservation station in the Tomasulo core.
- Holds up to DEPTH dispatched ALU instructions and snoops the common data bus for missing operands.
- Issues the oldest ready entry to an internal execution unit (single-cycle ALU plus multi-cycle multiplier).
- Presents the result with its reorder-buffer position on a valid/grant write-back port.

---
 rtl/alu_rs_multi_if.sv | 41 ++++
 rtl/alu_rs_multi.sv | 146 ++++++++++++++
 tb/tb_alu_rs_multi.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rs_multi_if.sv
// alu_rs_multi_if: dispatch, CDB snoop and write-back bundle for alu_rs_multi; flush exists only with ALU_RS_FLUSH_EN
interface alu_rs_multi_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FU_NUM = 16,
  parameter int FU_TAG_W = 4,
  parameter int ROB_IDX_W = 4,
  parameter int OP_W = 4
);
  logic disp_valid;
  logic disp_ready;
  logic [OP_W-1:0] disp_op;
  logic [ROB_IDX_W-1:0] disp_pos;
  logic [FU_TAG_W-1:0] disp_qj;
  logic [FU_TAG_W-1:0] disp_qk;
  logic [DATA_WIDTH-1:0] disp_vj;
  logic [DATA_WIDTH-1:0] disp_vk;
  logic [FU_NUM*DATA_WIDTH-1:0] cdb_data;
  logic [FU_NUM-1:0] cdb_valid;
  logic busy;
  logic wb_valid;
  logic [ROB_IDX_W-1:0] wb_pos;
  logic [DATA_WIDTH-1:0] wb_value;
  logic wb_grant;
`ifdef ALU_RS_FLUSH_EN
  logic flush;
`endif
  modport master (
    input disp_ready, busy, wb_valid, wb_pos, wb_value,
    output disp_valid, disp_op, disp_pos, disp_qj, disp_qk, disp_vj, disp_vk, cdb_data, cdb_valid, wb_grant
`ifdef ALU_RS_FLUSH_EN
    , output flush
`endif
  );
  modport slave (
    output disp_ready, busy, wb_valid, wb_pos, wb_value,
    input disp_valid, disp_op, disp_pos, disp_qj, disp_qk, disp_vj, disp_vk, cdb_data, cdb_valid, wb_grant
`ifdef ALU_RS_FLUSH_EN
    , input flush
`endif
  );
endinterface

// File: rtl/alu_rs_multi.sv
// alu_rs_multi: multi-entry ALU reservation station with CDB snoop, oldest-ready issue, ALU/MUL execution; ALU_RS_FLUSH_EN adds flush
module alu_rs_multi #(
  parameter int DEPTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FU_NUM = 16,
  parameter int FU_TAG_W = 4,
  parameter int ROB_IDX_W = 4,
  parameter int OP_W = 4,
  parameter int MUL_LATENCY = 3
) (
  input logic clk,
  input logic reset,
  alu_rs_multi_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(DATA_WIDTH);
  localparam int CW = $clog2(MUL_LATENCY + 1);
  localparam logic [OP_W-1:0] OPCODE_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OPCODE_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OPCODE_ADDI = OP_W'(2);
  localparam logic [OP_W-1:0] OPCODE_SUBI = OP_W'(3);
  localparam logic [OP_W-1:0] OPCODE_MUL = OP_W'(4);
  localparam logic [OP_W-1:0] OPCODE_SHL = OP_W'(5);
  localparam logic [OP_W-1:0] OPCODE_SHR = OP_W'(6);
  localparam logic [OP_W-1:0] OPCODE_BGE = OP_W'(7);
  logic [DEPTH-1:0] r_vld;
  logic [OP_W-1:0] r_op [DEPTH];
  logic [ROB_IDX_W-1:0] r_pos [DEPTH];
  logic [FU_TAG_W-1:0] r_qj [DEPTH];
  logic [FU_TAG_W-1:0] r_qk [DEPTH];
  logic [DATA_WIDTH-1:0] r_vj [DEPTH];
  logic [DATA_WIDTH-1:0] r_vk [DEPTH];
  logic [AW-1:0] r_age [DEPTH];
  logic r_ready, r_ex_busy, r_wb_valid;
  logic [CW-1:0] r_cnt;
  logic [ROB_IDX_W-1:0] r_ex_pos, r_wb_pos;
  logic [DATA_WIDTH-1:0] r_ex_val, r_wb_value;
  logic w_clr, w_acc, w_any, w_issue, w_long, w_fin, w_out_free, w_done, w_hj, w_hk;
  logic [AW-1:0] w_sel, w_free;
  logic [DEPTH-1:0] w_rdy, w_vld_nxt;
  logic [DATA_WIDTH-1:0] w_a, w_b, w_res, w_dj, w_dk;
  logic [OP_W-1:0] w_op;
`ifdef ALU_RS_FLUSH_EN
  assign w_clr = reset | bus.flush;
`else
  assign w_clr = reset;
`endif
  // age = number of younger valid entries, so the oldest ready entry has the largest age
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_free = '0;
    w_rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_rdy[i] = r_vld[i] && r_qj[i] == '0 && r_qk[i] == '0;
      w_free = r_vld[i] ? w_free : AW'(i);
    end
    for (int i = 0; i < DEPTH; i++)
      if (w_rdy[i] && (!w_any || r_age[i] > r_age[w_sel])) begin
        w_sel = AW'(i);
        w_any = 1'b1;
      end
  end
  assign w_a = r_vj[w_sel];
  assign w_b = r_vk[w_sel];
  assign w_op = r_op[w_sel];
  assign w_res = (w_op == OPCODE_ADD || w_op == OPCODE_ADDI) ? w_a + w_b :
                 (w_op == OPCODE_SUB || w_op == OPCODE_SUBI) ? w_a - w_b :
                 (w_op == OPCODE_MUL) ? w_a * w_b :
                 (w_op == OPCODE_SHL) ? w_a << w_b[SW-1:0] :
                 (w_op == OPCODE_SHR) ? w_a >> w_b[SW-1:0] :
                 (w_op == OPCODE_BGE) ? DATA_WIDTH'($signed(w_a) >= $signed(w_b)) : '0;
  assign w_long = (w_op == OPCODE_MUL) && (MUL_LATENCY > 1);
  assign w_out_free = !r_wb_valid || bus.wb_grant;
  assign w_fin = r_ex_busy && r_cnt == CW'(1);
  assign w_done = w_fin && w_out_free;
  // a single-cycle op writes the output register directly, so it cannot share a cycle with a finishing MUL
  assign w_issue = w_any && (w_long ? (!r_ex_busy || w_done) : (!r_ex_busy && w_out_free));
  assign w_acc = bus.disp_valid && r_ready;
  assign w_hj = bus.disp_qj != '0 && bus.cdb_valid[bus.disp_qj];
  assign w_hk = bus.disp_qk != '0 && bus.cdb_valid[bus.disp_qk];
  assign w_dj = w_hj ? bus.cdb_data[bus.disp_qj*DATA_WIDTH +: DATA_WIDTH] : bus.disp_vj;
  assign w_dk = w_hk ? bus.cdb_data[bus.disp_qk*DATA_WIDTH +: DATA_WIDTH] : bus.disp_vk;
  // occupancy after this edge: issued entry leaves, dispatched entry arrives
  always_comb begin
    w_vld_nxt = r_vld;
    if (w_issue) w_vld_nxt[w_sel] = 1'b0;
    if (w_acc) w_vld_nxt[w_free] = 1'b1;
  end
  // entry storage: allocate with same-cycle bypass, snoop the CDB, maintain relative age
  always_ff @(posedge clk) begin
    r_vld <= w_clr ? '0 : w_vld_nxt;
    r_ready <= w_clr ? 1'b1 : ~&w_vld_nxt;
    for (int i = 0; i < DEPTH; i++)
      if (w_acc && w_free == AW'(i)) begin
        r_op[i] <= bus.disp_op;
        r_pos[i] <= bus.disp_pos;
        r_qj[i] <= w_hj ? '0 : bus.disp_qj;
        r_qk[i] <= w_hk ? '0 : bus.disp_qk;
        r_vj[i] <= w_dj;
        r_vk[i] <= w_dk;
        r_age[i] <= '0;
      end else begin
        if (r_qj[i] != '0 && bus.cdb_valid[r_qj[i]]) begin
          r_qj[i] <= '0;
          r_vj[i] <= bus.cdb_data[r_qj[i]*DATA_WIDTH +: DATA_WIDTH];
        end
        if (r_qk[i] != '0 && bus.cdb_valid[r_qk[i]]) begin
          r_qk[i] <= '0;
          r_vk[i] <= bus.cdb_data[r_qk[i]*DATA_WIDTH +: DATA_WIDTH];
        end
        r_age[i] <= r_age[i] + AW'(w_acc) - AW'(w_issue && r_age[i] > r_age[w_sel]);
      end
  end
  // execution unit and output register: MUL counts down, the output register holds until granted
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_ex_busy <= 1'b0;
      r_cnt <= '0;
      r_ex_pos <= '0;
      r_ex_val <= '0;
      r_wb_valid <= 1'b0;
      r_wb_pos <= '0;
      r_wb_value <= '0;
    end else begin
      if (w_done) r_ex_busy <= 1'b0;
      else if (r_ex_busy && r_cnt != CW'(1)) r_cnt <= r_cnt - CW'(1);
      if (w_issue && w_long) begin
        r_ex_busy <= 1'b1;
        r_cnt <= CW'(MUL_LATENCY - 1);
        r_ex_pos <= r_pos[w_sel];
        r_ex_val <= w_res;
      end
      if (w_done || (w_issue && !w_long)) begin
        r_wb_valid <= 1'b1;
        r_wb_pos <= w_done ? r_ex_pos : r_pos[w_sel];
        r_wb_value <= w_done ? r_ex_val : w_res;
      end else if (bus.wb_grant) r_wb_valid <= 1'b0;
    end
  end
  assign bus.disp_ready = r_ready;
  assign bus.busy = |r_vld || r_ex_busy || r_wb_valid;
  assign bus.wb_valid = r_wb_valid;
  assign bus.wb_pos = r_wb_pos;
  assign bus.wb_value = r_wb_value;
endmodule

// File: tb/tb_alu_rs_multi.sv
// tb_alu_rs_multi: directed timing checks and random traffic against an in-order result-queue model
module tb_alu_rs_multi;
  localparam int ADD = 0, SUB = 1, ADDI = 2, SUBI = 3, MUL = 4, SHL = 5, SHR = 6, BGE = 7;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [35:0] q [$];
  alu_rs_multi_if bus ();
  alu_rs_multi dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      ADD, ADDI: return a + b;
      SUB, SUBI: return a - b;
      MUL: begin
        p = 64'(a) * 64'(b);
        return p[31:0];
      end
      SHL: return a << (b % 32);
      SHR: return a >> (b % 32);
      BGE: return (int'(a) >= int'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_wb(input string tag, input logic [31:0] v, input int pos);
    chk({tag, ".valid"}, bus.wb_valid, 1);
    chk({tag, ".value"}, bus.wb_value, v);
    chk({tag, ".pos"}, bus.wb_pos, pos);
  endtask
  task automatic chk_rst(input string tag);
    chk({tag, ".wb_valid"}, bus.wb_valid, 0);
    chk({tag, ".wb_pos"}, bus.wb_pos, 0);
    chk({tag, ".wb_value"}, bus.wb_value, 0);
    chk({tag, ".busy"}, bus.busy, 0);
    chk({tag, ".ready"}, bus.disp_ready, 1);
  endtask
  task automatic disp(input int op, input int pos, input int qj, input int qk, input logic [31:0] vj, input logic [31:0] vk);
    bus.disp_valid = 1'b1;
    bus.disp_op = 4'(op);
    bus.disp_pos = 4'(pos);
    bus.disp_qj = 4'(qj);
    bus.disp_qk = 4'(qk);
    bus.disp_vj = vj;
    bus.disp_vk = vk;
  endtask
  task automatic idle();
    bus.disp_valid = 1'b0;
    bus.cdb_valid = '0;
  endtask
  initial begin
    int so [4];
    logic [31:0] sa [4];
    logic [31:0] sb [4];
    int op, pos;
    logic [31:0] a, b;
    bus.disp_valid = 1'b0;
    bus.disp_op = '0;
    bus.disp_pos = '0;
    bus.disp_qj = '0;
    bus.disp_qk = '0;
    bus.disp_vj = '0;
    bus.disp_vk = '0;
    bus.cdb_data = '0;
    bus.cdb_valid = '0;
    bus.wb_grant = 1'b1;
`ifdef ALU_RS_FLUSH_EN
    bus.flush = 1'b0;
`endif
    step();
    step();
    chk_rst("reset");
    reset = 1'b0;
    // single ADD: wb two cycles after dispatch
    disp(ADD, 1, 0, 0, 5, 7);
    step();
    idle();
    chk("add.early", bus.wb_valid, 0);
    chk("add.busy", bus.busy, 1);
    step();
    chk_wb("add", 12, 1);
    step();
    chk("add.drain", bus.wb_valid, 0);
    chk("add.idle", bus.busy, 0);
    // back-to-back single-cycle ops
    so = '{SUB, SHL, SHR, BGE};
    sa = '{32'd5, 32'd5, 32'd5, 32'd7};
    sb = '{32'd7, 32'd7, 32'd1, 32'd1};
    for (int k = 0; k < 6; k++) begin
      if (k < 4) disp(so[k], 2 + k, 0, 0, sa[k], sb[k]);
      else idle();
      if (k >= 2) chk_wb("b2b", ref_alu(so[k-2], sa[k-2], sb[k-2]), k);
      step();
    end
    chk("b2b.drain", bus.wb_valid, 0);
    // MUL followed by ADD: ADD waits behind MUL
    disp(MUL, 6, 0, 0, 5, 7);
    step();
    disp(ADD, 7, 0, 0, 1, 1);
    step();
    idle();
    chk("mul.n2", bus.wb_valid, 0);
    step();
    chk("mul.n3", bus.wb_valid, 0);
    step();
    chk_wb("mul", ref_alu(MUL, 5, 7), 6);
    step();
    chk_wb("mul.add", 2, 7);
    step();
    chk("mul.drain", bus.wb_valid, 0);
    // operand arrives on the CDB five cycles later; decoys on other slots
    disp(ADD, 8, 3, 0, 32'hdead, 4);
    step();
    idle();
    bus.cdb_data[5*32 +: 32] = 32'd77;
    bus.cdb_data[0 +: 32] = 32'd99;
    for (int k = 1; k < 5; k++) begin
      bus.cdb_valid = 16'h0021;
      chk("snoop.wait", bus.wb_valid, 0);
      step();
    end
    bus.cdb_valid = 16'h0008;
    bus.cdb_data[3*32 +: 32] = 32'd10;
    step();
    idle();
    chk("snoop.c1", bus.wb_valid, 0);
    step();
    chk_wb("snoop", 14, 8);
    step();
    // same-cycle bypass on both operands
    disp(SUB, 9, 6, 11, 0, 0);
    bus.cdb_valid = 16'h0840;
    bus.cdb_data[6*32 +: 32] = 32'd100;
    bus.cdb_data[11*32 +: 32] = 32'd30;
    step();
    idle();
    chk("byp.early", bus.wb_valid, 0);
    step();
    chk_wb("byp", 70, 9);
    step();
    // fill the station waiting on tag 2
    for (int k = 0; k < 4; k++) begin
      chk("fill.ready", bus.disp_ready, 1);
      disp(ADD, 10 + k, 2, 0, 0, k + 1);
      step();
    end
    chk("full.ready", bus.disp_ready, 0);
    disp(ADD, 15, 0, 0, 1, 1);
    step();
    idle();
    chk("full.ready2", bus.disp_ready, 0);
    bus.cdb_valid = 16'h0004;
    bus.cdb_data[2*32 +: 32] = 32'd1000;
    step();
    idle();
    chk("full.ready3", bus.disp_ready, 0);
    chk("full.nowb", bus.wb_valid, 0);
    step();
    chk("full.freed", bus.disp_ready, 1);
    for (int k = 0; k < 4; k++) begin
      chk_wb("full.order", 1001 + k, 10 + k);
      step();
    end
    chk("full.drain", bus.wb_valid, 0);
    chk("full.idle", bus.busy, 0);
    // back-pressure: output register frozen while not granted
    bus.wb_grant = 1'b0;
    disp(ADD, 1, 0, 0, 2, 3);
    step();
    disp(SUB, 2, 0, 0, 9, 2);
    step();
    idle();
    for (int k = 0; k < 4; k++) begin
      chk_wb("hold", 5, 1);
      chk("hold.busy", bus.busy, 1);
      step();
    end
    bus.wb_grant = 1'b1;
    chk_wb("hold.rel", 5, 1);
    step();
    chk_wb("hold.next", 7, 2);
    step();
    chk("hold.drain", bus.wb_valid, 0);
    // reset in the middle of a MUL with a waiting entry
    disp(MUL, 3, 0, 0, 3, 4);
    step();
    disp(ADD, 4, 7, 0, 1, 1);
    step();
    idle();
    reset = 1'b1;
    step();
    chk_rst("midmul");
    reset = 1'b0;
    bus.cdb_valid = 16'h0080;
    bus.cdb_data[7*32 +: 32] = 32'd5;
    for (int k = 0; k < 4; k++) begin
      step();
      idle();
      chk("midmul.quiet", bus.wb_valid, 0);
      chk("midmul.idle", bus.busy, 0);
    end
`ifdef ALU_RS_FLUSH_EN
    // flush with a pending result, a MUL in flight and a dispatch in the flush cycle
    bus.wb_grant = 1'b0;
    disp(ADD, 5, 0, 0, 1, 1);
    step();
    disp(MUL, 6, 0, 0, 3, 4);
    step();
    disp(ADD, 7, 0, 0, 2, 2);
    step();
    bus.wb_grant = 1'b1;
    bus.flush = 1'b1;
    disp(ADD, 8, 0, 0, 4, 4);
    step();
    bus.flush = 1'b0;
    idle();
    chk_rst("flush");
    for (int k = 0; k < 4; k++) begin
      step();
      chk("flush.quiet", bus.wb_valid, 0);
      chk("flush.idle", bus.busy, 0);
    end
`endif
    // random traffic with random grant, all operands present
    for (int c = 0; c < 600; c++) begin
      bus.wb_grant = ($urandom_range(0, 3) != 0);
      if (bus.wb_valid) begin
        if (q.size() == 0) chk("rnd.extra", bus.wb_valid, 0);
        else begin
          chk("rnd.value", bus.wb_value, q[0][31:0]);
          chk("rnd.pos", bus.wb_pos, q[0][35:32]);
          if (bus.wb_grant) void'(q.pop_front());
        end
      end
      if ($urandom_range(0, 2) != 0) begin
        op = $urandom_range(0, 9);
        pos = $urandom_range(0, 15);
        a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
        b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        disp(op, pos, 0, 0, a, b);
        if (bus.disp_ready) q.push_back({4'(pos), ref_alu(op, a, b)});
      end else idle();
      step();
    end
    bus.wb_grant = 1'b1;
    idle();
    for (int c = 0; c < 40 && q.size() > 0; c++) begin
      if (bus.wb_valid) begin
        chk("drain.value", bus.wb_value, q[0][31:0]);
        chk("drain.pos", bus.wb_pos, q[0][35:32]);
        void'(q.pop_front());
      end
      step();
    end
    chk("drain.empty", q.size(), 0);
    chk("drain.idle", bus.busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
